// File: rtl/periph_to_csb_if.sv
// Peripheral request/response bus plus NVDLA CSB bus seen by the bridge.
// The slave modport is the bridge's view; the master modport is the
// environment's view (peripheral initiator + CSB target combined).
interface periph_to_csb_if #(
  parameter int ID_WIDTH = 8
) ();
  // peripheral request side
  logic                per_req_i;
  logic                per_gnt_o;
  logic [31:0]         per_add_i;
  logic                per_wen_i;
  logic [31:0]         per_wdata_i;
  logic [3:0]          per_be_i;
  logic [ID_WIDTH-1:0] per_id_i;
  // peripheral response side
  logic                per_r_valid_o;
  logic [31:0]         per_r_rdata_o;
  logic                per_r_opc_o;
  logic [ID_WIDTH-1:0] per_r_id_o;
  // CSB side
  logic                csb_valid_o;
  logic                csb_ready_i;
  logic [15:0]         csb_addr_o;
  logic [31:0]         csb_wdat_o;
  logic                csb_write_o;
  logic                csb_nposted_o;
  logic                csb_r_valid_i;
  logic [31:0]         csb_r_data_i;
  logic                csb_wr_complete_i;

  modport slave (
    input  per_req_i, per_add_i, per_wen_i, per_wdata_i, per_be_i, per_id_i,
    output per_gnt_o,
    output per_r_valid_o, per_r_rdata_o, per_r_opc_o, per_r_id_o,
    output csb_valid_o, csb_addr_o, csb_wdat_o, csb_write_o, csb_nposted_o,
    input  csb_ready_i, csb_r_valid_i, csb_r_data_i, csb_wr_complete_i
  );

  modport master (
    output per_req_i, per_add_i, per_wen_i, per_wdata_i, per_be_i, per_id_i,
    input  per_gnt_o,
    input  per_r_valid_o, per_r_rdata_o, per_r_opc_o, per_r_id_o,
    input  csb_valid_o, csb_addr_o, csb_wdat_o, csb_write_o, csb_nposted_o,
    output csb_ready_i, csb_r_valid_i, csb_r_data_i, csb_wr_complete_i
  );
endinterface

// File: rtl/periph_to_csb.sv
// Bridge from a req/gnt peripheral bus to the NVDLA CSB register bus.
// One transaction outstanding at a time; responses are registered and
// carry the request ID back. Waits for CSB responses are bounded by an
// optional timeout that answers with an error and 0xDEADBEEF.
module periph_to_csb #(
  parameter int ID_WIDTH = 8,
  parameter bit NPOSTED  = 1'b0,
  parameter int TIMEOUT  = 1024
) (
  input  logic           csb_clk,
  input  logic           rst_i,
  periph_to_csb_if.slave bus,
  output logic           busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RD,
    ST_WAIT_WR,
    ST_RESP
  } state_e;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [15:0]         addr_q, addr_d;
  logic [31:0]         wdat_q, wdat_d;
  logic                write_q, write_d;
  logic                nposted_q, nposted_d;
  logic                csb_valid_q, csb_valid_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                r_valid_q, r_valid_d;
  logic [31:0]         r_rdata_q, r_rdata_d;
  logic                r_opc_q, r_opc_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic                gnt;
  logic                timeout_hit;
  logic                unused_add;

  // Only the word address inside the 256 KiB CSB window is forwarded.
  assign unused_add  = ^{bus.per_add_i[31:18], bus.per_add_i[1:0]};
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Next-state, payload capture and response formation.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    write_d   = write_q;
    nposted_d = nposted_q;
    cnt_d     = cnt_q;
    r_rdata_d = r_rdata_q;
    r_opc_d   = r_opc_q;
    r_id_d    = r_id_q;
    gnt       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        gnt = bus.per_req_i;
        if (bus.per_req_i) begin
          id_d      = bus.per_id_i;
          addr_d    = bus.per_add_i[17:2];
          wdat_d    = bus.per_wdata_i;
          write_d   = ~bus.per_wen_i;
          nposted_d = NPOSTED & ~bus.per_wen_i;
          // CSB has no byte enables: sub-word writes are refused locally.
          if (!bus.per_wen_i && (bus.per_be_i != 4'hF)) begin
            state_d   = ST_RESP;
            r_rdata_d = 32'h0;
            r_opc_d   = 1'b1;
            r_id_d    = bus.per_id_i;
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (bus.csb_ready_i) begin
          cnt_d = 16'h0;
          if (!write_q) begin
            state_d = ST_WAIT_RD;
          end else if (nposted_q) begin
            state_d = ST_WAIT_WR;
          end else begin
            state_d   = ST_RESP;
            r_rdata_d = 32'h0;
            r_opc_d   = 1'b0;
            r_id_d    = id_q;
          end
        end
      end

      ST_WAIT_RD: begin
        // A response arriving on the timeout cycle still counts as success.
        if (bus.csb_r_valid_i) begin
          state_d   = ST_RESP;
          r_rdata_d = bus.csb_r_data_i;
          r_opc_d   = 1'b0;
          r_id_d    = id_q;
        end else if (timeout_hit) begin
          state_d   = ST_RESP;
          r_rdata_d = 32'hDEADBEEF;
          r_opc_d   = 1'b1;
          r_id_d    = id_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_WAIT_WR: begin
        if (bus.csb_wr_complete_i) begin
          state_d   = ST_RESP;
          r_rdata_d = 32'h0;
          r_opc_d   = 1'b0;
          r_id_d    = id_q;
        end else if (timeout_hit) begin
          state_d   = ST_RESP;
          r_rdata_d = 32'hDEADBEEF;
          r_opc_d   = 1'b1;
          r_id_d    = id_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    csb_valid_d = (state_d == ST_REQ);
    r_valid_d   = (state_d == ST_RESP);
  end

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge csb_clk) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      addr_q      <= 16'h0;
      wdat_q      <= 32'h0;
      write_q     <= 1'b0;
      nposted_q   <= 1'b0;
      csb_valid_q <= 1'b0;
      cnt_q       <= 16'h0;
      r_valid_q   <= 1'b0;
      r_rdata_q   <= 32'h0;
      r_opc_q     <= 1'b0;
      r_id_q      <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      write_q     <= write_d;
      nposted_q   <= nposted_d;
      csb_valid_q <= csb_valid_d;
      cnt_q       <= cnt_d;
      r_valid_q   <= r_valid_d;
      r_rdata_q   <= r_rdata_d;
      r_opc_q     <= r_opc_d;
      r_id_q      <= r_id_d;
    end
  end

  assign busy_o            = (state_q != ST_IDLE);
  assign bus.per_gnt_o     = gnt;
  assign bus.csb_valid_o   = csb_valid_q;
  assign bus.csb_addr_o    = addr_q;
  assign bus.csb_wdat_o    = wdat_q;
  assign bus.csb_write_o   = write_q;
  assign bus.csb_nposted_o = nposted_q;
  assign bus.per_r_valid_o = r_valid_q;
  assign bus.per_r_rdata_o = r_rdata_q;
  assign bus.per_r_opc_o   = r_opc_q;
  assign bus.per_r_id_o    = r_id_q;

endmodule

// File: doc/periph_to_csb.md
PERIPH_TO_CSB -- requirements
Module: periph_to_csb

Interface
REQ-001 The module SHALL have parameter ID_WIDTH, default 8, setting the width of the peripheral transaction ID.
REQ-002 The module SHALL have parameter NPOSTED, default 0, setting the csb_nposted_o value for writes: 1 means non-posted, wait for wr_complete; 0 means posted.
REQ-003 The module SHALL have parameter TIMEOUT, default 1024, setting the response-wait limit in cycles; 0 disables the timeout.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset: csb_clk  in  1  clock; rst_i  in  1  sync active-high reset.
REQ-005 The module SHALL have the following peripheral-side ports:
- per_req_i  in  1  request.
- per_gnt_o  out  1  grant.
- per_add_i  in  32  byte address.
- per_wen_i  in  1  1=read, 0=write.
- per_wdata_i  in  32  write data.
- per_be_i  in  4  byte enables.
- per_id_i  in  ID_WIDTH  request ID.
REQ-006 The module SHALL have the following response ports:
- per_r_valid_o  out  1  response valid.
- per_r_rdata_o  out  32  read data.
- per_r_opc_o  out  1  1=error.
- per_r_id_o  out  ID_WIDTH  echoed ID.
REQ-007 The module SHALL have the following NVDLA CSB-side ports:
- csb_valid_o  out  1
- csb_ready_i  in  1
- csb_addr_o  out  16  word address
- csb_wdat_o  out  32
- csb_write_o  out  1
- csb_nposted_o  out  1
- csb_r_valid_i  in  1
- csb_r_data_i  in  32
- csb_wr_complete_i  in  1
REQ-008 The module SHALL have busy_o  out  1, high whenever the FSM is not in IDLE.

Function
REQ-009 The FSM SHALL have exactly five states: IDLE, REQ, WAIT_RD, WAIT_WR, RESP; only one transaction is ever outstanding.
REQ-010 per_gnt_o SHALL equal per_req_i in IDLE (combinational) and 0 in all other states; a request is accepted when per_req_i and per_gnt_o are both high.
REQ-011 On acceptance the module SHALL register the following, then enter REQ:
- per_id_i;
- csb_addr_o = per_add_i[17:2];
- csb_wdat_o = per_wdata_i;
- csb_write_o = ~per_wen_i;
- csb_nposted_o = NPOSTED when writing, else 0.
REQ-012 A write accepted with per_be_i != 4'hF SHALL bypass CSB and go directly to RESP with opc=1 and rdata=0; reads ignore per_be_i.
REQ-013 csb_valid_o SHALL be 1 exactly in REQ and the REQ payload SHALL be held stable until csb_ready_i=1.
REQ-014 When csb_ready_i=1 in REQ, the FSM SHALL transition as follows:
- read: to WAIT_RD;
- non-posted write: to WAIT_WR;
- posted write: to RESP with opc=0 and rdata=0.
REQ-015 In WAIT_RD, csb_r_valid_i=1 SHALL capture csb_r_data_i into rdata with opc=0 and go to RESP.
REQ-016 In WAIT_WR, csb_wr_complete_i=1 SHALL go to RESP with opc=0 and rdata=0.
REQ-017 In RESP, per_r_valid_o SHALL be 1 for exactly one cycle together with rdata, opc and the stored ID, and the FSM SHALL then return to IDLE.
REQ-018 A new request SHALL be grantable in the cycle after RESP.
REQ-019 Latency, with acceptance at cycle N:
- csb_valid_o is high in cycle N+1;
- a posted write with ready at N+1 gives per_r_valid_o at N+2;
- a read whose csb_r_valid_i arrives at cycle M gives per_r_valid_o at M+1.
REQ-020 The 16-bit timeout counter SHALL behave as follows:
- it clears on entering WAIT_RD or WAIT_WR and increments each cycle in those states;
- when TIMEOUT != 0 and the count reaches TIMEOUT-1 with no response, the FSM SHALL go to RESP with opc=1 and rdata=32'hDEADBEEF;
- there is no timeout in REQ.
REQ-021 csb_r_valid_i outside WAIT_RD and csb_wr_complete_i outside WAIT_WR SHALL be ignored with no state change; this includes a late response after a timeout.
REQ-022 If a response and the timeout occur in the same cycle, the response SHALL win (opc=0).
REQ-023 per_r_* outputs SHALL be registered; per_r_rdata_o, per_r_opc_o and per_r_id_o are don't-care when per_r_valid_o=0 but SHALL hold their last values.

Reset
REQ-024 rst_i=1 SHALL force, on the next csb_clk edge, state IDLE, all outputs 0 (except per_gnt_o, which follows REQ-010), and the counter 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction with no response, and post-reset CSB responses SHALL be ignored per REQ-021.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Read: add=0x0000_5008, wen=1, id=0x3C; CSB ready at once; r_valid with data 0x1234_5678 three cycles later -> csb_addr_o=0x1402, then per_r_valid_o one cycle after r_valid with rdata=0x12345678, opc=0, id=0x3C.
- Posted write (NPOSTED=0): add=0x10, wdata=0xA5A5_0001, be=F; csb_ready_i held low 4 cycles -> csb_valid_o and payload stable all 4 cycles, csb_write_o=1, nposted=0; per_r_valid_o one cycle after the handshake with opc=0.
- Non-posted write (NPOSTED=1): wr_complete 10 cycles after handshake -> per_r_valid_o exactly one cycle after wr_complete; csb_r_valid_i pulsed during the wait is ignored.
- Partial write be=4'h3 -> csb_valid_o never asserts; per_r_valid_o at N+1 with opc=1.
- Timeout (TIMEOUT=16): read with no csb_r_valid_i -> response 16 cycles after entering WAIT_RD with opc=1 and rdata=0xDEADBEEF; a late csb_r_valid_i is ignored.
- Reset pulsed in WAIT_RD -> busy_o=0 next cycle, no per_r_valid_o, and a following request is serviced normally.
